// File: rtl/wb_charlieplex_pkg.sv
// Shared constants and the LED-index to pin-pair mapping for the charlieplex driver.
package wb_charlieplex_pkg;

  localparam int unsigned DEF_PINS     = 7;
  localparam int unsigned DEF_PWM_BITS = 4;
  localparam int unsigned DEF_CLK_DIV  = 1024;

  typedef struct packed {
    logic [7:0] anode;
    logic [7:0] cathode;
  } pin_map_t;

  // Each anode owns PINS-1 LEDs; the cathode skips over the anode's own pin.
  function automatic pin_map_t pin_map(input int unsigned k, input int unsigned pins);
    pin_map_t    m;
    int unsigned a;
    int unsigned j;
    a         = k / (pins - 1);
    j         = k % (pins - 1);
    m.anode   = 8'(a);
    m.cathode = 8'((j < a) ? j : j + 1);
    return m;
  endfunction

endpackage

// File: rtl/wb_charlieplex_scan.sv
// Slot scanner: prescaler, PWM tick counter, LED index, active-level latch, pin registers.
// Macro WB_CHARLIEPLEX_BLANK_EN adds one dark tick at the end of every slot.
module wb_charlieplex_scan
  import wb_charlieplex_pkg::*;
#(
  parameter int unsigned PINS     = DEF_PINS,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [PWM_BITS-1:0]                 i_level_next,
  output logic [$clog2(PINS*(PINS-1))-1:0]    o_k_next,
  output logic [PINS-1:0]                     o_pins,
  output logic [PINS-1:0]                     o_oe
);

  localparam int unsigned LEDS = PINS * (PINS - 1);
  localparam int unsigned KW   = $clog2(LEDS);
  localparam int unsigned PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW   = PWM_BITS + 1;
`ifdef WB_CHARLIEPLEX_BLANK_EN
  localparam int unsigned T_LAST = 2 ** PWM_BITS;
`else
  localparam int unsigned T_LAST = 2 ** PWM_BITS - 1;
`endif

  logic [PW-1:0]       r_pre;
  logic [TW-1:0]       r_t;
  logic [KW-1:0]       r_k;
  logic [PWM_BITS-1:0] r_act;
  logic [PINS-1:0]     r_pins;
  logic [PINS-1:0]     r_oe;

  logic                w_tick;
  logic                w_lit;
  logic [KW-1:0]       w_k_next;
  logic [31:0]         w_k_int;
  pin_map_t            w_map;
  logic [PINS-1:0]     w_a_mask;
  logic [PINS-1:0]     w_c_mask;

  always_comb begin
    w_tick   = (r_pre == PW'(CLK_DIV - 1));
    w_k_next = (r_k == KW'(LEDS - 1)) ? '0 : r_k + 1'b1;
    w_k_int  = 32'(r_k);
    w_map    = pin_map(w_k_int, PINS);
    w_a_mask = PINS'(1) << w_map.anode;
    w_c_mask = PINS'(1) << w_map.cathode;
    // The blank tick (t = 2^PWM_BITS) always exceeds any level, so it stays dark.
    w_lit    = (r_t < {1'b0, r_act});
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre  <= '0;
      r_t    <= '0;
      r_k    <= '0;
      r_act  <= '0;
      r_pins <= '0;
      r_oe   <= '0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        if (r_t == TW'(T_LAST)) begin
          r_t   <= '0;
          r_k   <= w_k_next;
          r_act <= i_level_next;
        end else begin
          r_t <= r_t + 1'b1;
        end
      end
      r_oe   <= w_lit ? (w_a_mask | w_c_mask) : '0;
      r_pins <= w_lit ? w_a_mask : '0;
    end
  end

  assign o_k_next = w_k_next;
  assign o_pins   = r_pins;
  assign o_oe     = r_oe;

endmodule

// File: rtl/wb_charlieplex.sv
// Wishbone classic slave holding per-LED PWM levels, driving a charlieplexed LED matrix.
// Macro WB_CHARLIEPLEX_BLANK_EN enables a dead tick per slot (see wb_charlieplex_scan).
module wb_charlieplex
  import wb_charlieplex_pkg::*;
#(
  parameter int unsigned PINS     = DEF_PINS,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb_cyc,
  input  logic                              wb_stb,
  input  logic                              wb_we,
  input  logic [$clog2(PINS*(PINS-1))-1:0]  wb_adr,
  input  logic [7:0]                        wb_dat_i,
  output logic [7:0]                        wb_dat_o,
  output logic                              wb_ack,
  output logic [PINS-1:0]                   charlieplex_o,
  output logic [PINS-1:0]                   charlieplex_oe
);

  localparam int unsigned    LEDS   = PINS * (PINS - 1);
  localparam int unsigned    AW     = $clog2(LEDS);
  localparam logic [AW:0]    LEDS_W = LEDS[AW:0];

  logic [PWM_BITS-1:0] r_level [LEDS];
  logic                r_ack;
  logic [7:0]          r_dat;

  logic                w_req;
  logic                w_hit;
  logic [AW-1:0]       w_k_next;
  logic [PWM_BITS-1:0] w_level_next;

  always_comb begin
    w_req        = wb_cyc & wb_stb & ~r_ack;
    w_hit        = ({1'b0, wb_adr} < LEDS_W);
    w_level_next = r_level[w_k_next];
  end

  // Data is sampled on the edge that raises ack; out-of-range addresses ack with zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      for (int unsigned i = 0; i < LEDS; i++) begin
        r_level[i] <= '0;
      end
    end else begin
      r_ack <= w_req;
      r_dat <= '0;
      if (w_req && w_hit) begin
        if (wb_we) begin
          r_level[wb_adr] <= wb_dat_i[PWM_BITS-1:0];
        end else begin
          r_dat <= 8'(r_level[wb_adr]);
        end
      end
    end
  end

  wb_charlieplex_scan #(
    .PINS     (PINS),
    .PWM_BITS (PWM_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_scan (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_level_next (w_level_next),
    .o_k_next     (w_k_next),
    .o_pins       (charlieplex_o),
    .o_oe         (charlieplex_oe)
  );

  assign wb_ack   = r_ack;
  assign wb_dat_o = r_dat;

endmodule

// File: tb/tb_wb_charlieplex.sv
// Directed bench for wb_charlieplex with PINS=3, PWM_BITS=2, CLK_DIV=2.
module tb_wb_charlieplex;

`ifdef WB_CHARLIEPLEX_BLANK_EN
  localparam int SL = 5;
`else
  localparam int SL = 4;
`endif
  localparam int FR = 2 * SL * 6;

  localparam logic [2:0] OE_MAP [6] = '{3'b011, 3'b101, 3'b011, 3'b110, 3'b101, 3'b110};
  localparam logic [2:0] O_MAP  [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wb_cyc = 1'b0;
  logic       wb_stb = 1'b0;
  logic       wb_we = 1'b0;
  logic [2:0] wb_adr = '0;
  logic [7:0] wb_dat_i = '0;
  logic [7:0] wb_dat_o;
  logic       wb_ack;
  logic [2:0] charlieplex_o;
  logic [2:0] charlieplex_oe;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int exp_lvl [0:4][0:5];
  int max_pop = 0;

  wb_charlieplex #(
    .PINS     (3),
    .PWM_BITS (2),
    .CLK_DIV  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_cyc         (wb_cyc),
    .wb_stb         (wb_stb),
    .wb_we          (wb_we),
    .wb_adr         (wb_adr),
    .wb_dat_i       (wb_dat_i),
    .wb_dat_o       (wb_dat_o),
    .wb_ack         (wb_ack),
    .charlieplex_o  (charlieplex_o),
    .charlieplex_oe (charlieplex_oe)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
    logic [7:0] exp;
  } bus_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int target);
    int guard = 0;
    while (cyc != target && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (cyc != target) begin
      total++;
      $display("FAIL wait_cyc: got cyc %0d expected %0d", cyc, target);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                          output logic [7:0] rd);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    @(posedge clk); #1;
    chk($sformatf("ack_next_cycle adr=%0d", adr), 32'(wb_ack), 1);
    rd = wb_dat_o;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("ack_one_cycle adr=%0d", adr), 32'(wb_ack), 0);
  endtask

  // Output after edge n reflects scan state after edge n-1 (counted from reset release).
  task automatic check_frames(input int n_first, input int n_last);
    int m, slot, k, fr, t, pop;
    logic [2:0] eoe, eo;
    wait_cyc(n_first);
    for (int n = n_first; n <= n_last; n++) begin
      m    = n - 1;
      slot = m / (2 * SL);
      k    = slot % 6;
      fr   = slot / 6;
      t    = (m / 2) % SL;
      eoe  = (t < exp_lvl[fr][k]) ? OE_MAP[k] : 3'b000;
      eo   = (t < exp_lvl[fr][k]) ? O_MAP[k]  : 3'b000;
      chk($sformatf("scan_oe n=%0d k=%0d t=%0d", n, k, t), 32'(charlieplex_oe), 32'(eoe));
      chk($sformatf("scan_o n=%0d k=%0d t=%0d", n, k, t), 32'(charlieplex_o), 32'(eo));
      pop = $countones(charlieplex_oe);
      if (pop > max_pop) max_pop = pop;
      @(posedge clk); #1;
    end
  endtask

  bus_vec_t   vecs [12];
  logic [7:0] rd;
  logic       seen_ack, seen_out;
  logic [3:0] pat;

  initial begin
    vecs[0]  = '{1'b1, 3'd0, 8'h03, 8'h00};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'h03};
    vecs[2]  = '{1'b0, 3'd7, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 3'd5, 8'h02, 8'h00};
    vecs[4]  = '{1'b0, 3'd5, 8'h00, 8'h02};
    vecs[5]  = '{1'b1, 3'd6, 8'h01, 8'h00};
    vecs[6]  = '{1'b0, 3'd6, 8'h00, 8'h00};
    vecs[7]  = '{1'b1, 3'd3, 8'h7D, 8'h00};
    vecs[8]  = '{1'b0, 3'd3, 8'h00, 8'h01};
    vecs[9]  = '{1'b0, 3'd1, 8'h00, 8'h00};
    vecs[10] = '{1'b1, 3'd0, 8'hFC, 8'h00};
    vecs[11] = '{1'b0, 3'd0, 8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_oe", 32'(charlieplex_oe), 0);
    chk("reset_o", 32'(charlieplex_o), 0);
    chk("reset_ack", 32'(wb_ack), 0);
    chk("reset_dat_o", 32'(wb_dat_o), 0);
    rst = 1'b0;

    seen_ack = 1'b0; seen_out = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (wb_ack) seen_ack = 1'b1;
      if (charlieplex_oe != 3'b000 || charlieplex_o != 3'b000) seen_out = 1'b1;
    end
    chk("idle_ack", 32'(seen_ack), 0);
    chk("idle_pins", 32'(seen_out), 0);

    for (int i = 0; i < 12; i++) begin
      bus_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, rd);
      if (!vecs[i].we) chk($sformatf("read_data vec=%0d", i), 32'(rd), 32'(vecs[i].exp));
    end

    // Held strobe: ack must drop for a cycle between back-to-back transfers.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = wb_ack;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    chk("ack_gap_pattern", 32'(pat), 32'(4'b0101));

    // Reset during a write strobe: no ack, and the write never lands.
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 3'd1; wb_dat_i = 8'h03; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ack_1", 32'(wb_ack), 0);
    @(posedge clk); #1;
    chk("abort_ack_2", 32'(wb_ack), 0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    bus_xfer(1'b0, 3'd1, 8'h00, rd);
    chk("abort_no_write", 32'(rd), 0);

    // Scan: known phase from reset release.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int f = 0; f < 5; f++)
      for (int k = 0; k < 6; k++) exp_lvl[f][k] = 0;
    for (int f = 1; f < 5; f++) begin
      exp_lvl[f][0] = (f >= 3) ? 3 : 2;
      exp_lvl[f][3] = 1;
    end
    bus_xfer(1'b1, 3'd0, 8'h02, rd);
    bus_xfer(1'b1, 3'd3, 8'h01, rd);
    fork
      check_frames(FR + 1, 4 * FR);
      begin
        wait_cyc(2 * FR + 3);
        bus_xfer(1'b1, 3'd0, 8'h03, rd);
      end
    join
    chk("oe_at_most_two", 32'(max_pop <= 2), 1);

    wait_cyc(4 * FR + 2);
    chk("pre_rst_lit_oe", 32'(charlieplex_oe), 32'(3'b011));
    chk("pre_rst_lit_o", 32'(charlieplex_o), 32'(3'b001));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midslot_rst_oe", 32'(charlieplex_oe), 0);
    chk("midslot_rst_o", 32'(charlieplex_o), 0);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) exp_lvl[0][k] = 0;
    exp_lvl[0][2] = 3;
    fork
      check_frames(1, FR);
      bus_xfer(1'b1, 3'd2, 8'h03, rd);
    join

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
